// File: rtl/branch_flag_generator.sv
// Purpose : multi-cycle a-b subtractor producing Carry/Zero/Overflow/Sign flags for branch decisions.
// Latency : start accepted at edge k -> done pulse and final flags in the cycle after edge k+N (N=WIDTH/CHUNK).
// Backpr. : none; start is only sampled in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request, accepted only when idle
//   operand_a, operand_b     minuend / subtrahend, captured on start acceptance
//   busy                     high while slices are being processed
//   done                     one-cycle pulse when the flags are final
//   Carry_Flag               1 = a >= b unsigned (carry-out of a + ~b + 1)
//   Zero_Flag                1 = a == b
//   Overflow_Flag            signed overflow of a - b
//   Sign_Flag                MSB of a - b
//
// Build option: define BRANCH_FLAG_CLEAR_ON_START_EN to clear all flags on start
// acceptance, so stale flags are never visible while busy.

module branch_flag_generator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             Carry_Flag,
    output logic             Zero_Flag,
    output logic             Overflow_Flag,
    output logic             Sign_Flag
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_zero;
    logic              r_done;
    logic              r_c_flag;
    logic              r_z_flag;
    logic              r_v_flag;
    logic              r_s_flag;

    // Operands are shifted right one slice per cycle, so the slice being
    // worked on always sits in the low CHUNK bits; on the last slice those
    // bits are the top slice and bit CHUNK-1 is the operand MSB.
    logic [CHUNK-1:0]  w_a_sl;
    logic [CHUNK-1:0]  w_b_sl;
    logic [CHUNK:0]    w_sum;
    logic              w_zero_nxt;
    logic              w_ovf;

    assign w_a_sl     = r_a[CHUNK-1:0];
    assign w_b_sl     = r_b[CHUNK-1:0];
    assign w_sum      = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + (CHUNK+1)'(r_carry);
    assign w_zero_nxt = r_zero & (w_sum[CHUNK-1:0] == '0);
    assign w_ovf      = (w_a_sl[CHUNK-1] != w_b_sl[CHUNK-1]) &
                        (w_sum[CHUNK-1]  != w_a_sl[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == IDXW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
            r_v_flag <= 1'b0;
            r_s_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= operand_a;
                r_b     <= operand_b;
                r_idx   <= '0;
                r_carry <= 1'b1;   // the +1 of two's-complement negation of b
                r_zero  <= 1'b1;
`ifdef BRANCH_FLAG_CLEAR_ON_START_EN
                r_c_flag <= 1'b0;
                r_z_flag <= 1'b0;
                r_v_flag <= 1'b0;
                r_s_flag <= 1'b0;
`endif
            end else if (r_state == RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
                r_carry <= w_sum[CHUNK];
                r_zero  <= w_zero_nxt;
                if (w_last) begin
                    r_c_flag <= w_sum[CHUNK];
                    r_z_flag <= w_zero_nxt;
                    r_v_flag <= w_ovf;
                    r_s_flag <= w_sum[CHUNK-1];
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done          = r_done;
    assign Carry_Flag    = r_c_flag;
    assign Zero_Flag     = r_z_flag;
    assign Overflow_Flag = r_v_flag;
    assign Sign_Flag     = r_s_flag;

endmodule

// File: doc/branch_flag_generator.md
Name: branch_flag_generator

Overview:
Multi-cycle subtractor that produces the Carry, Zero, Overflow and Sign flags consumed by the branch decision logic.
- Computes operand_a − operand_b in CHUNK-bit slices, one slice per cycle, LSB slice first.
- Registers the four flags and pulses done when they are final.
- Sits between the register-file read ports and branch control; replaces the full-width ALU compare path for branches in the multi-cycle datapath.

Parameters:
WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK slice cycles (N=1 allowed).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
operand_a  input  WIDTH  minuend (rs1 value), captured on start acceptance
operand_b  input  WIDTH  subtrahend (rs2 value), captured on start acceptance
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse, flags final
Carry_Flag  output  1  carry-out of a + ~b + 1 (1 = a ≥ b unsigned)
Zero_Flag  output  1  1 = full-width result is zero
Overflow_Flag  output  1  signed overflow of a − b
Sign_Flag  output  1  MSB of result

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, all four flags=0.
  - Internal operands, slice index and accumulators are cleared.
  - Reset mid-operation aborts it: no done pulse, and flags are not updated.
- FSM: IDLE, RUN.
  - IDLE: if start=1, capture operand_a/operand_b, set slice index=0, carry_acc=1, zero_acc=1, busy=1, go to RUN. If start=0, stay in IDLE.
  - RUN, every edge, for slice i:
    - sum = a[i] + ~b[i] + carry_acc, computed as CHUNK+1 bits.
    - carry_acc ← bit CHUNK of sum.
    - zero_acc ← zero_acc & (sum[CHUNK-1:0]==0).
    - i ← i+1.
  - RUN, last slice (i=N−1), on the same edge:
    - Carry_Flag ← final carry_acc; Zero_Flag ← final zero_acc.
    - Sign_Flag ← sum[CHUNK-1].
    - Overflow_Flag ← carry into the MSB XOR carry out of the MSB, equivalently (a_msb ≠ b_msb) & (sign ≠ a_msb).
    - done ← 1, busy ← 0, go to IDLE.
- Latency: start accepted at edge k; done=1 and flags valid during the cycle after edge k+N. Back-to-back throughput is one result per N+1 cycles.
- Pulses and holds:
  - done stays high exactly one cycle.
  - Flags hold their values until the next completion or reset.
- start while busy=1 is ignored (not queued). start in the same cycle that done=1 is accepted, since state is IDLE.
- Operand inputs are don't-care except in the cycle start is accepted.
- Flag semantics match branch control:
  - BEQ/BNE use Z; BLT/BGE use V≠S; BLTU/BGEU use C.
- Slice index counter is ceil(log2(N)) bits, minimum 1; no wrap beyond N−1.

Optional Feature:
Macro BRANCH_FLAG_CLEAR_ON_START_EN.
- Defined: on start acceptance, all four flags are cleared to 0 on the same edge, so stale flags are never visible while busy=1.
- Not defined: flags keep the previous result until the new done edge.
- All other timing is identical in both builds.

Test Plan:
1. WIDTH=32, CHUNK=8; rst for 2 cycles → busy=0, done=0, C=Z=V=S=0. Then a=5, b=5, start pulse → done exactly 4 cycles after the start edge; Z=1, C=1, V=0, S=0.
2. a=3, b=7 → Z=0, C=0, S=1, V=0; result 0xFFFFFFFC (BLT and BLTU taken).
3. a=0x80000000, b=0x00000001 → result 0x7FFFFFFF; Z=0, C=1, S=0, V=1 (BLT taken via V≠S).
4. a=0x01000000, b=0 → Z=0, because only the top slice is nonzero; C=1, S=0, V=0. Also a=0, b=0xFFFFFFFF → C=0, Z=0, S=0, V=0.
5. start held high continuously with a=9, b=2 → done pulses every 5 cycles. Changing operands while busy has no effect on the in-flight result.
6. Start a=1, b=1, assert rst 2 cycles later → no done pulse, flags=0, busy=0. With BRANCH_FLAG_CLEAR_ON_START_EN defined, run case 3 then case 1: flags read 0 during busy, then Z=1, C=1 at done. Without the macro, flags keep S=0, V=1, C=1 while busy.
